bcd_convert_arbiter: RTL and testbench

Sequential arbiter and sequencer that shares one combinational 3-digit binary-to-BCD converter between two requesters. Each requester presents a binary value under a level Req / pulse Ack handshake. The block latches the granted value into the converter and waits a fixed settle time. It then captures the three BCD digits into registered outputs and acknowledges the requester. It sits between control logic, such as display drivers or report formatters, and the shared converter datapath.

---
 rtl/bcd_arb_pkg.sv | 33 +++
 rtl/bcd_convert_arbiter_bin2bcd.sv | 29 ++
 rtl/bcd_convert_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bcd_convert_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM encodings, digit sizing
// and the double-dabble step used by the shared converter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int DIGIT_WIDTH      = 4;
  localparam int NUM_DIGITS       = 3;
  localparam int BCD_WIDTH        = NUM_DIGITS * DIGIT_WIDTH;
  localparam int MAX_BCD_VALUE    = 999;
  localparam int SETTLE_CNT_WIDTH = 4;

  // One shift-add-3 step: correct every digit >= 5, then shift the next binary bit in.
  // The top bit shifted out only matters for values above 999.
  function automatic logic [BCD_WIDTH-1:0] dabble_step(
    input logic [BCD_WIDTH-1:0] bcd,
    input logic                 bin_bit
  );
    logic [BCD_WIDTH-1:0] adj;
    adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[d*DIGIT_WIDTH +: DIGIT_WIDTH] > DIGIT_WIDTH'(4)) begin
        adj[d*DIGIT_WIDTH +: DIGIT_WIDTH] = bcd[d*DIGIT_WIDTH +: DIGIT_WIDTH] + DIGIT_WIDTH'(3);
      end
    end
    return (adj << 1) | BCD_WIDTH'(bin_bit);
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_bin2bcd.sv
// Bin2BCDConverter3: purely combinational binary to 3-digit BCD converter,
// unrolled double-dabble chain. Digits are exact for inputs up to 999.
module Bin2BCDConverter3
  import bcd_arb_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 16
) (
  input  logic [INPUT_BIT_WIDTH-1:0] BinIn,
  output logic [DIGIT_WIDTH-1:0]     Digit2,
  output logic [DIGIT_WIDTH-1:0]     Digit1,
  output logic [DIGIT_WIDTH-1:0]     Digit0
);

  logic [BCD_WIDTH-1:0] stage [0:INPUT_BIT_WIDTH];

  assign stage[0] = '0;

  // MSB first: stage gi+1 has absorbed the top gi+1 input bits.
  generate
    for (genvar gi = 0; gi < INPUT_BIT_WIDTH; gi++) begin : g_dabble
      assign stage[gi+1] = dabble_step(stage[gi], BinIn[INPUT_BIT_WIDTH-1-gi]);
    end
  endgenerate

  assign Digit2 = stage[INPUT_BIT_WIDTH][2*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign Digit1 = stage[INPUT_BIT_WIDTH][1*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign Digit0 = stage[INPUT_BIT_WIDTH][0*DIGIT_WIDTH +: DIGIT_WIDTH];

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter/sequencer sharing one Bin2BCDConverter3 between two requesters.
// Optional BCD_ARB_SATURATE_EN: values above 999 capture as 9,9,9 with Overflow set.
module bcd_convert_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 16,
  parameter int SETTLE_CYCLES   = 1
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       Req0,
  input  logic [INPUT_BIT_WIDTH-1:0] Value0,
  output logic                       Ack0,
  input  logic                       Req1,
  input  logic [INPUT_BIT_WIDTH-1:0] Value1,
  output logic                       Ack1,
  output logic [DIGIT_WIDTH-1:0]     Digit2,
  output logic [DIGIT_WIDTH-1:0]     Digit1,
  output logic [DIGIT_WIDTH-1:0]     Digit0,
  output logic                       Overflow,
  output logic                       ResultValid,
  output logic                       Busy,
  output logic                       GrantId
);

  arb_state_t                  state_reg, state_next;
  logic                        last_reg, last_next;
  logic                        grant_reg, grant_next;
  logic [INPUT_BIT_WIDTH-1:0]  conv_in_reg, conv_in_next;
  logic [SETTLE_CNT_WIDTH-1:0] settle_cnt_reg, settle_cnt_next;
  logic                        capture;
  logic                        winner;
  logic [DIGIT_WIDTH-1:0]      conv_digit2, conv_digit1, conv_digit0;
  logic [DIGIT_WIDTH-1:0]      digit2_reg, digit1_reg, digit0_reg;
  logic [DIGIT_WIDTH-1:0]      digit2_next, digit1_next, digit0_next;
  logic [1:0]                  ack;

  Bin2BCDConverter3 #(
    .INPUT_BIT_WIDTH(INPUT_BIT_WIDTH)
  ) u_conv (
    .BinIn  (conv_in_reg),
    .Digit2 (conv_digit2),
    .Digit1 (conv_digit1),
    .Digit0 (conv_digit0)
  );

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign winner = Req1 & (~Req0 | ~last_reg);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;
      grant_reg      <= 1'b0;
      conv_in_reg    <= '0;
      settle_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      last_reg       <= last_next;
      grant_reg      <= grant_next;
      conv_in_reg    <= conv_in_next;
      settle_cnt_reg <= settle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_next       = last_reg;
    grant_next      = grant_reg;
    conv_in_next    = conv_in_reg;
    settle_cnt_next = settle_cnt_reg;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Req0 || Req1) begin
          grant_next      = winner;
          conv_in_next    = winner ? Value1 : Value0;
          settle_cnt_next = SETTLE_CNT_WIDTH'(SETTLE_CYCLES);
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_next = settle_cnt_reg - SETTLE_CNT_WIDTH'(1);
        // A count of 0 can only come from an illegal setting; capture rather than stall.
        if (settle_cnt_reg <= SETTLE_CNT_WIDTH'(1)) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        last_next  = grant_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BCD_ARB_SATURATE_EN
  logic conv_over;
  logic overflow_reg, overflow_next;

  generate
    if (INPUT_BIT_WIDTH > 9) begin : g_over
      assign conv_over = conv_in_reg > INPUT_BIT_WIDTH'(MAX_BCD_VALUE);
    end else begin : g_no_over
      assign conv_over = 1'b0;
    end
  endgenerate

  always_comb begin
    digit2_next   = digit2_reg;
    digit1_next   = digit1_reg;
    digit0_next   = digit0_reg;
    overflow_next = overflow_reg;
    if (capture) begin
      digit2_next   = conv_over ? DIGIT_WIDTH'(9) : conv_digit2;
      digit1_next   = conv_over ? DIGIT_WIDTH'(9) : conv_digit1;
      digit0_next   = conv_over ? DIGIT_WIDTH'(9) : conv_digit0;
      overflow_next = conv_over;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= overflow_next;
    end
  end

  assign Overflow = overflow_reg;
`else
  always_comb begin
    digit2_next = digit2_reg;
    digit1_next = digit1_reg;
    digit0_next = digit0_reg;
    if (capture) begin
      digit2_next = conv_digit2;
      digit1_next = conv_digit1;
      digit0_next = conv_digit0;
    end
  end

  assign Overflow = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      digit2_reg <= '0;
      digit1_reg <= '0;
      digit0_reg <= '0;
    end else begin
      digit2_reg <= digit2_next;
      digit1_reg <= digit1_next;
      digit0_reg <= digit0_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign Ack0        = ack[0];
  assign Ack1        = ack[1];
  assign ResultValid = state_reg == DONE;
  assign Busy        = state_reg != IDLE;
  assign GrantId     = grant_reg;
  assign Digit2      = digit2_reg;
  assign Digit1      = digit1_reg;
  assign Digit0      = digit0_reg;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter: a scoreboard of expected results
// (digits, requester, arrival cycle) is compared on every Ack by a monitor.
module tb_bcd_convert_arbiter;

  localparam int W = 16;
  localparam int S = 1;

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         Req0 = 1'b0;
  logic         Req1 = 1'b0;
  logic [W-1:0] Value0 = '0;
  logic [W-1:0] Value1 = '0;
  logic         Ack0, Ack1, Overflow, ResultValid, Busy, GrantId;
  logic [3:0]   Digit2, Digit1, Digit0;

  bcd_convert_arbiter #(
    .INPUT_BIT_WIDTH(W),
    .SETTLE_CYCLES  (S)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Req0       (Req0),
    .Value0     (Value0),
    .Ack0       (Ack0),
    .Req1       (Req1),
    .Value1     (Value1),
    .Ack1       (Ack1),
    .Digit2     (Digit2),
    .Digit1     (Digit1),
    .Digit0     (Digit0),
    .Overflow   (Overflow),
    .ResultValid(ResultValid),
    .Busy       (Busy),
    .GrantId    (GrantId)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    bit       id;
    bit [3:0] d2, d1, d0;
    bit       ovf;
    int       at;
    int       value;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic exp_t mk(input bit id, input int v, input int at);
    exp_t e;
    e.id    = id;
    e.value = v;
    e.at    = at;
    e.d2    = 4'((v / 100) % 10);
    e.d1    = 4'((v / 10) % 10);
    e.d0    = 4'(v % 10);
    e.ovf   = 1'b0;
`ifdef BCD_ARB_SATURATE_EN
    if (v > 999) begin
      e.d2  = 4'd9;
      e.d1  = 4'd9;
      e.d0  = 4'd9;
      e.ovf = 1'b1;
    end
`endif
    return e;
  endfunction

  // Scoreboard monitor: every Ack pops one expected result.
  always @(negedge Clock) begin
    if (nReset && (Ack0 || Ack1 || ResultValid)) begin
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: cyc=%0d Ack0=%0b Ack1=%0b ResultValid=%0b, none expected",
                 cyc, Ack0, Ack1, ResultValid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Ack0 !== !e.id || Ack1 !== e.id || ResultValid !== 1'b1 ||
            Digit2 !== e.d2 || Digit1 !== e.d1 || Digit0 !== e.d0 ||
            Overflow !== e.ovf || cyc != e.at) begin
          n_fail++;
          $display("FAIL result_value%0d: got cyc=%0d Ack0=%0b Ack1=%0b RV=%0b digits=%0d,%0d,%0d ovf=%0b; want cyc=%0d req=%0d digits=%0d,%0d,%0d ovf=%0b",
                   e.value, cyc, Ack0, Ack1, ResultValid, Digit2, Digit1, Digit0, Overflow,
                   e.at, e.id, e.d2, e.d1, e.d0, e.ovf);
        end else begin
          $display("ack req%0d value=%0d digits=%0d,%0d,%0d ovf=%0b cyc=%0d",
                   e.id, e.value, Digit2, Digit1, Digit0, Overflow, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_ack(input bit which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge Clock);
      if ((which ? Ack1 : Ack0) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    nReset = 1'b0;
    tick(1);
    nReset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(2);
    n_assert++;
    if ({Ack0, Ack1, ResultValid, Busy, GrantId, Overflow, Digit2, Digit1, Digit0} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_state: got Ack0=%0b Ack1=%0b RV=%0b Busy=%0b Grant=%0b ovf=%0b digits=%0d,%0d,%0d, want all 0",
               Ack0, Ack1, ResultValid, Busy, GrantId, Overflow, Digit2, Digit1, Digit0);
    end
    nReset = 1'b1;
    tick(2);
    $display("reset released cyc=%0d", cyc);
  endtask

  task automatic test_single();
    bit ok;
    Value0 = W'(142);
    Req0   = 1'b1;
    sb.push_back(mk(0, 142, cyc + 1 + S));
    tick(1);
    n_assert++;
    if (Busy !== 1'b1 || GrantId !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: got Busy=%0b GrantId=%0b, want 1 0", Busy, GrantId);
    end
    wait_ack(0, 10, ok);
    Req0 = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: Ack0 not seen, want within 10 cycles");
    end
    tick(3);
    n_assert++;
    if ({Digit2, Digit1, Digit0} !== 12'h142 || Busy !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got digits=%0d,%0d,%0d Busy=%0b ovf=%0b, want 1,4,2 0 0",
               Digit2, Digit1, Digit0, Busy, Overflow);
    end
  endtask

  task automatic test_tie();
    bit ok0, ok1;
    int t;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      Value0 = (r == 0) ? W'(89) : W'(5);
      Value1 = (r == 0) ? W'(33) : W'(7);
      Req0 = 1'b1;
      Req1 = 1'b1;
      t = cyc;
      sb.push_back(mk(0, int'(Value0), t + 1 + S));
      sb.push_back(mk(1, int'(Value1), t + 1 + S + S + 2));
      wait_ack(0, 10, ok0);
      Req0 = 1'b0;
      wait_ack(1, 10, ok1);
      Req1 = 1'b0;
      n_assert++;
      if (!ok0 || !ok1) begin
        n_fail++;
        $display("FAIL tie_timeout%0d: got ack0_seen=%0b ack1_seen=%0b, want both 1", r, ok0, ok1);
      end
      tick(1);
    end
  endtask

  task automatic test_value_change();
    bit ok;
    Value1 = W'(599);
    Req1   = 1'b1;
    sb.push_back(mk(1, 599, cyc + 1 + S));
    tick(1);
    Value1 = W'(0);
    wait_ack(1, 10, ok);
    Req1 = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL value_change_timeout: Ack1 not seen, want within 10 cycles");
    end
    tick(1);
  endtask

  task automatic test_boundary();
    bit ok;
    int vals[$];
    vals = {999, 0, 100, 9};
`ifdef BCD_ARB_SATURATE_EN
    vals.push_back(1234);
    vals.push_back(1000);
`endif
    foreach (vals[i]) begin
      Value0 = W'(vals[i]);
      Req0   = 1'b1;
      sb.push_back(mk(0, vals[i], cyc + 1 + S));
      wait_ack(0, 10, ok);
      Req0 = 1'b0;
      n_assert++;
      if (!ok) begin
        n_fail++;
        $display("FAIL boundary_timeout: value %0d got no Ack0, want one", vals[i]);
      end
      tick(1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    Value0 = W'(10);
    Req0   = 1'b1;
    tick(1);
    nReset = 1'b0;
    Req0   = 1'b0;
    #1;
    n_assert++;
    if (Busy !== 1'b0 || Ack0 !== 1'b0 || {Digit2, Digit1, Digit0} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: got Busy=%0b Ack0=%0b digits=%0d,%0d,%0d, want 0 0 0,0,0",
               Busy, Ack0, Digit2, Digit1, Digit0);
    end
    tick(2);
    nReset = 1'b1;
    tick(4);
    Req0 = 1'b1;
    sb.push_back(mk(0, 10, cyc + 1 + S));
    wait_ack(0, 10, ok);
    Req0 = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_reissue_timeout: Ack0 not seen, want within 10 cycles");
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t;
    Value0 = W'(0);
    Req0   = 1'b1;
    t = cyc;
    for (int i = 0; i < 4; i++) sb.push_back(mk(0, 0, t + 1 + S + i * (S + 2)));
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, 10, ok);
      n_assert++;
      if (!ok) begin
        n_fail++;
        $display("FAIL back_to_back_timeout%0d: Ack0 not seen, want within 10 cycles", i);
      end
    end
    Req0 = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_value_change();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
